issueq_int: RTL and testbench

//   Integer issue queue directly upstream of the issue unit. Holds dispatched

---
 rtl/issue_pkg.sv | 38 +++
 rtl/issueq_int_if.sv | 46 ++++
 rtl/issueq_select.sv | 12 +
 rtl/issueq_int.sv | 117 +++++++++++
 tb/tb_issueq_int.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// Shared types for the issue queues: entry layout and the CDB wakeup helper.
package issue_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 6;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rsdata;
    logic [TAG_W-1:0]  rstag;
    logic              rsvalid;
    logic [DATA_W-1:0] rtdata;
    logic [TAG_W-1:0]  rttag;
    logic              rtvalid;
    logic [TAG_W-1:0]  rdtag;
  } iq_entry_t;

  // Captures a matching CDB broadcast into any still-pending operand.
  // Also used at dispatch, which gives the same-cycle bypass.
  function automatic iq_entry_t iq_wake(iq_entry_t e, logic cv,
                                        logic [TAG_W-1:0] tag,
                                        logic [DATA_W-1:0] data);
    iq_entry_t r;
    r = e;
    if (e.valid && cv) begin
      if (!e.rsvalid && e.rstag == tag) begin
        r.rsdata  = data;
        r.rsvalid = 1'b1;
      end
      if (!e.rtvalid && e.rttag == tag) begin
        r.rtdata  = data;
        r.rtvalid = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/issueq_int_if.sv
// Dispatch, CDB and issue-bus signals of the integer issue queue.
interface issueq_int_if
  import issue_pkg::*;
#(
  parameter int CNT_W = 3
);
  logic              issueq_flush;
  logic              dispatch_en;
  logic [OPC_W-1:0]  dispatch_opcode;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic              dispatch_rsvalid;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tagout;
  logic [DATA_W-1:0] cdb_out;
  logic              issueint_equeueint_done;
  logic              issueq_full;
  logic [CNT_W-1:0]  issueq_count;
  logic              issueint_ready;
  logic [OPC_W-1:0]  issueint_opcode;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;
  logic [TAG_W-1:0]  issueint_rdtag;

  modport master (
    output issueq_flush, dispatch_en, dispatch_opcode,
           dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tagout, cdb_out, issueint_equeueint_done,
    input  issueq_full, issueq_count, issueint_ready, issueint_opcode,
           issueint_rsdata, issueint_rtdata, issueint_rdtag
  );

  modport slave (
    input  issueq_flush, dispatch_en, dispatch_opcode,
           dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid, dispatch_rdtag,
           cdb_valid, cdb_tagout, cdb_out, issueint_equeueint_done,
    output issueq_full, issueq_count, issueint_ready, issueint_opcode,
           issueint_rsdata, issueint_rtdata, issueint_rdtag
  );
endinterface

// File: rtl/issueq_select.sv
// Lowest-index priority encoder: one-hot grant plus any-request flag.
module issueq_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);
  // Two's-complement trick isolates the least significant set bit.
  assign grant = req & (~req + N'(1));
  assign any   = |req;
endmodule

// File: rtl/issueq_int.sv
// Integer issue queue: age-ordered collapsing entries with CDB wakeup,
// oldest-ready select and single-op removal per cycle.
module issueq_int
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         reset,
  issueq_int_if.slave bus
);
  iq_entry_t [DEPTH-1:0] q;
  iq_entry_t [DEPTH-1:0] nxt;
  iq_entry_t [DEPTH:0]   woke;
  iq_entry_t             new_e;
  logic [CNT_W-1:0]      count, count_nxt, slot;
  logic [DEPTH-1:0]      req, grant, shift;
  logic                  any, full, remove, accept;

  logic [OPC_W-1:0]  sel_opcode;
  logic [DATA_W-1:0] sel_rsdata, sel_rtdata;
  logic [TAG_W-1:0]  sel_rdtag;

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      req[i] = q[i].valid & q[i].rsvalid & q[i].rtvalid;
  end

  issueq_select #(.N(DEPTH)) u_sel (
    .req   (req),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    sel_opcode = '0;
    sel_rsdata = '0;
    sel_rtdata = '0;
    sel_rdtag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_opcode = sel_opcode | q[i].opcode;
        sel_rsdata = sel_rsdata | q[i].rsdata;
        sel_rtdata = sel_rtdata | q[i].rtdata;
        sel_rdtag  = sel_rdtag  | q[i].rdtag;
      end
    end
  end

  assign full   = (count == CNT_W'(DEPTH));
  assign remove = bus.issueint_equeueint_done & any;
  // Full is judged on registered state, so a same-cycle removal cannot admit it.
  assign accept = bus.dispatch_en & ~full;
  assign slot   = count - CNT_W'(remove);

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.opcode  = bus.dispatch_opcode;
    new_e.rsdata  = bus.dispatch_rsdata;
    new_e.rstag   = bus.dispatch_rstag;
    new_e.rsvalid = bus.dispatch_rsvalid;
    new_e.rtdata  = bus.dispatch_rtdata;
    new_e.rttag   = bus.dispatch_rttag;
    new_e.rtvalid = bus.dispatch_rtvalid;
    new_e.rdtag   = bus.dispatch_rdtag;
    new_e = iq_wake(new_e, bus.cdb_valid, bus.cdb_tagout, bus.cdb_out);
  end

  // Extra top slot stays empty so the collapse can read one past the end.
  always_comb begin
    woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++)
      woke[i] = iq_wake(q[i], bus.cdb_valid, bus.cdb_tagout, bus.cdb_out);
  end

  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      seen     = seen | grant[i];
      shift[i] = remove & seen;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = shift[i] ? woke[i+1] : woke[i];
      if (accept && slot == CNT_W'(i))
        nxt[i] = new_e;
    end
  end

  assign count_nxt = count + CNT_W'(accept) - CNT_W'(remove);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      count <= '0;
    end else if (bus.issueq_flush) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= nxt;
      count <= count_nxt;
    end
  end

  assign bus.issueq_full     = full;
  assign bus.issueq_count    = count;
  assign bus.issueint_ready  = any;
  assign bus.issueint_opcode = sel_opcode;
  assign bus.issueint_rsdata = sel_rsdata;
  assign bus.issueint_rtdata = sel_rtdata;
  assign bus.issueint_rdtag  = sel_rdtag;
endmodule

// File: tb/tb_issueq_int.sv
// Directed bench for issueq_int: reset, select order, wakeup, bypass, full, flush.
module tb_issueq_int;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  issueq_int_if #(.CNT_W(3)) bus ();

  issueq_int #(.DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issueq_flush            = 1'b0;
    bus.dispatch_en             = 1'b0;
    bus.dispatch_opcode         = '0;
    bus.dispatch_rsdata         = '0;
    bus.dispatch_rstag          = '0;
    bus.dispatch_rsvalid        = 1'b0;
    bus.dispatch_rtdata         = '0;
    bus.dispatch_rttag          = '0;
    bus.dispatch_rtvalid        = 1'b0;
    bus.dispatch_rdtag          = '0;
    bus.cdb_valid               = 1'b0;
    bus.cdb_tagout              = '0;
    bus.cdb_out                 = '0;
    bus.issueint_equeueint_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] rsd, input logic [5:0] rst,
                      input logic rsv, input logic [31:0] rtd, input logic [5:0] rtt,
                      input logic rtv, input logic [5:0] rd);
    bus.dispatch_en      = 1'b1;
    bus.dispatch_opcode  = op;
    bus.dispatch_rsdata  = rsd;
    bus.dispatch_rstag   = rst;
    bus.dispatch_rsvalid = rsv;
    bus.dispatch_rtdata  = rtd;
    bus.dispatch_rttag   = rtt;
    bus.dispatch_rtvalid = rtv;
    bus.dispatch_rdtag   = rd;
  endtask

  task automatic take();
    bus.issueint_equeueint_done = 1'b1;
    tick();
    bus.issueint_equeueint_done = 1'b0;
  endtask

  initial begin
    // Reset held with dispatch active
    idle();
    reset = 1'b0;
    disp(6'd1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd5);
    tick(); tick();
    chk("rst_count", bus.issueq_count, 0);
    chk("rst_ready", bus.issueint_ready, 0);
    chk("rst_full", bus.issueq_full, 0);
    chk("rst_rdtag", bus.issueint_rdtag, 0);
    chk("rst_rsdata", bus.issueint_rsdata, 0);
    idle();
    reset = 1'b1;
    tick();

    // Ready dispatch and removal
    disp(6'd1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd5);
    tick(); idle();
    chk("rdy_ready", bus.issueint_ready, 1);
    chk("rdy_opcode", bus.issueint_opcode, 1);
    chk("rdy_rsdata", bus.issueint_rsdata, 3);
    chk("rdy_rtdata", bus.issueint_rtdata, 4);
    chk("rdy_rdtag", bus.issueint_rdtag, 5);
    chk("rdy_count", bus.issueq_count, 1);
    take();
    chk("rdy_done_ready", bus.issueint_ready, 0);
    chk("rdy_done_count", bus.issueq_count, 0);

    // Wakeup via CDB two cycles after dispatch
    disp(6'd2, 32'd0, 6'd9, 1'b0, 32'd7, 6'd0, 1'b1, 6'd10);
    tick(); idle();
    chk("wk_wait_ready", bus.issueint_ready, 0);
    chk("wk_wait_count", bus.issueq_count, 1);
    tick();
    bus.cdb_valid  = 1'b1;
    bus.cdb_tagout = 6'd9;
    bus.cdb_out    = 32'hAB;
    #1;
    chk("wk_same_cycle", bus.issueint_ready, 0);
    tick(); idle();
    chk("wk_ready", bus.issueint_ready, 1);
    chk("wk_rsdata", bus.issueint_rsdata, 32'hAB);
    chk("wk_rtdata", bus.issueint_rtdata, 7);
    chk("wk_rdtag", bus.issueint_rdtag, 10);
    take();
    chk("wk_drain", bus.issueq_count, 0);

    // Oldest ready first, collapse ordering
    disp(6'd2, 32'd0, 6'd7, 1'b0, 32'd1, 6'd0, 1'b1, 6'd11);
    tick();
    disp(6'd3, 32'h10, 6'd0, 1'b1, 32'h11, 6'd0, 1'b1, 6'd12);
    tick();
    disp(6'd4, 32'h20, 6'd0, 1'b1, 32'h21, 6'd0, 1'b1, 6'd13);
    tick(); idle();
    chk("age_count3", bus.issueq_count, 3);
    chk("age_first_B", bus.issueint_rdtag, 12);
    chk("age_B_rsdata", bus.issueint_rsdata, 32'h10);
    take();
    chk("age_count2", bus.issueq_count, 2);
    chk("age_then_C", bus.issueint_rdtag, 13);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tagout = 6'd7;
    bus.cdb_out    = 32'h77;
    tick(); idle();
    chk("age_A_woken", bus.issueint_rdtag, 11);
    chk("age_A_rsdata", bus.issueint_rsdata, 32'h77);
    chk("age_A_opcode", bus.issueint_opcode, 2);
    take();
    chk("age_count1", bus.issueq_count, 1);
    chk("age_last_C", bus.issueint_rdtag, 13);
    take();
    chk("age_count0", bus.issueq_count, 0);
    chk("age_empty_ready", bus.issueint_ready, 0);

    // Full, dropped dispatch with simultaneous removal, bypass
    for (int i = 0; i < 4; i++) begin
      disp(6'd5, 32'd100 + i, 6'd0, 1'b1, 32'd200 + i, 6'd0, 1'b1, 6'(20 + i));
      tick();
    end
    idle();
    chk("full_flag", bus.issueq_full, 1);
    chk("full_count", bus.issueq_count, 4);
    chk("full_head", bus.issueint_rdtag, 20);
    disp(6'd5, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd24);
    take(); idle();
    chk("drop_count", bus.issueq_count, 3);
    chk("drop_full", bus.issueq_full, 0);
    chk("drop_head", bus.issueint_rdtag, 21);
    disp(6'd6, 32'd0, 6'd30, 1'b0, 32'd0, 6'd30, 1'b0, 6'd25);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tagout = 6'd30;
    bus.cdb_out    = 32'hBEEF;
    tick(); idle();
    chk("byp_count", bus.issueq_count, 4);
    chk("byp_full", bus.issueq_full, 1);
    take();
    chk("byp_order22", bus.issueint_rdtag, 22);
    take();
    chk("byp_order23", bus.issueint_rdtag, 23);
    take();
    chk("byp_ready", bus.issueint_ready, 1);
    chk("byp_rdtag", bus.issueint_rdtag, 25);
    chk("byp_rsdata", bus.issueint_rsdata, 32'hBEEF);
    chk("byp_rtdata", bus.issueint_rtdata, 32'hBEEF);
    take();
    chk("byp_drain", bus.issueq_count, 0);

    // Flush overrides dispatch, done and wakeup
    disp(6'd7, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd40);
    tick();
    disp(6'd7, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd41);
    tick();
    chk("fl_pre_count", bus.issueq_count, 2);
    disp(6'd7, 32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 1'b1, 6'd42);
    bus.issueq_flush            = 1'b1;
    bus.issueint_equeueint_done = 1'b1;
    bus.cdb_valid               = 1'b1;
    bus.cdb_tagout              = 6'd1;
    tick(); idle();
    chk("fl_count", bus.issueq_count, 0);
    chk("fl_ready", bus.issueint_ready, 0);
    chk("fl_rdtag", bus.issueint_rdtag, 0);
    tick();
    chk("fl_stays_empty", bus.issueq_count, 0);

    // Asynchronous reset mid-operation
    disp(6'd8, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 6'd50);
    tick(); idle();
    chk("ar_pre_count", bus.issueq_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_count", bus.issueq_count, 0);
    chk("ar_ready", bus.issueint_ready, 0);
    chk("ar_rdtag", bus.issueint_rdtag, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_after", bus.issueq_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
